// File: rtl/alu_ctrl.sv
// rtl/alu_ctrl.sv - command/response sequencer driving an external 16-bit ALU (optional ALU_CTRL_COND_EN)
module alu_ctrl #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int RAW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [RAW-1:0]   cmd_rd,
  input  logic [RAW-1:0]   cmd_rs1,
  input  logic [RAW-1:0]   cmd_rs2,
  input  logic             cmd_use_imm,
  input  logic [WIDTH-1:0] cmd_imm,
  input  logic [1:0]       cmd_cond,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_z,
  output logic             rsp_sign,
  output logic             rsp_err,
  output logic             rsp_skip,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_z,
  input  logic             alu_sign,
  output logic             flag_z,
  output logic             flag_s
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] OP_ALU_MAX = 4'd8;
  localparam logic [3:0] OP_LOAD    = 4'd15;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] rf_q [NREGS];
  logic [3:0]       op_q;
  logic [RAW-1:0]   rd_q;
  logic [WIDTH-1:0] imm_q;
  logic             cond_ok_q, cond_ok_d;
  logic             flag_z_q, flag_s_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q;
  logic [3:0]       alu_ctl_q;
  logic             rsp_valid_q, rsp_z_q, rsp_sign_q, rsp_err_q, rsp_skip_q;
  logic [WIDTH-1:0] rsp_data_q;

  logic             accept, in_exec, is_alu, is_load, is_illegal, wb_en;
  logic [WIDTH-1:0] res_data;
  logic             res_z, res_sign;

  assign accept     = (state_q == S_IDLE) && cmd_valid;
  assign in_exec    = (state_q == S_EXEC);
  assign is_alu     = (op_q <= OP_ALU_MAX);
  assign is_load    = (op_q == OP_LOAD);
  assign is_illegal = !is_alu && !is_load;
  assign wb_en      = in_exec && !is_illegal && cond_ok_q;

  // Condition is judged on the architectural flags as they stand at accept
`ifdef ALU_CTRL_COND_EN
  always_comb begin
    cond_ok_d = 1'b1;
    case (cmd_cond)
      2'd0:    cond_ok_d = 1'b1;
      2'd1:    cond_ok_d = flag_z_q;
      2'd2:    cond_ok_d = !flag_z_q;
      default: cond_ok_d = flag_s_q;
    endcase
  end
`else
  logic unused_cond;
  assign unused_cond = ^cmd_cond;
  assign cond_ok_d   = 1'b1;
`endif

  // Result of the executing op; illegal ops report zero data and flags
  always_comb begin
    res_data = '0;
    res_z    = 1'b0;
    res_sign = 1'b0;
    if (is_load) begin
      res_data = imm_q;
      res_z    = (imm_q == '0);
      res_sign = imm_q[WIDTH-1];
    end else if (is_alu) begin
      res_data = alu_y;
      res_z    = alu_z;
      res_sign = alu_sign;
    end
  end

  // Sequencer: IDLE -> EXEC (one cycle) -> RESP (until consumed)
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Capture command and drive ALU operands at accept; held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      cond_ok_q <= 1'b1;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_ctl_q <= '0;
    end else if (accept) begin
      op_q      <= cmd_op;
      rd_q      <= cmd_rd;
      imm_q     <= cmd_imm;
      cond_ok_q <= cond_ok_d;
      alu_a_q   <= rf_q[cmd_rs1];
      alu_b_q   <= cmd_use_imm ? cmd_imm : rf_q[cmd_rs2];
      alu_ctl_q <= (cmd_op <= OP_ALU_MAX) ? cmd_op : 4'd0;
    end
  end

  // Register file and architectural flags, written only at the end of EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      flag_z_q <= 1'b0;
      flag_s_q <= 1'b0;
    end else if (wb_en) begin
      rf_q[rd_q] <= res_data;
      flag_z_q   <= res_z;
      flag_s_q   <= res_sign;
    end
  end

  // Response registers: loaded at end of EXEC, held until the handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_z_q     <= 1'b0;
      rsp_sign_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_skip_q  <= 1'b0;
    end else if (in_exec) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= res_data;
      rsp_z_q     <= res_z;
      rsp_sign_q  <= res_sign;
      rsp_err_q   <= is_illegal;
      rsp_skip_q  <= !cond_ok_q;
    end else if (state_q == S_RESP && rsp_ready) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_skip_q  <= 1'b0;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_sign  = rsp_sign_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_skip  = rsp_skip_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_ctl   = alu_ctl_q;
  assign flag_z    = flag_z_q;
  assign flag_s    = flag_s_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// tb/tb_alu_ctrl.sv - self-checking bench for alu_ctrl with a behavioural ALU and register-file model
module tb_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_use_imm;
  logic [3:0]  cmd_op;
  logic [2:0]  cmd_rd, cmd_rs1, cmd_rs2;
  logic [15:0] cmd_imm;
  logic [1:0]  cmd_cond;
  logic        rsp_valid, rsp_ready, rsp_z, rsp_sign, rsp_err, rsp_skip;
  logic [15:0] rsp_data, alu_a, alu_b, alu_y;
  logic [3:0]  alu_ctl;
  logic        alu_z, alu_sign, flag_z, flag_s;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] m_rf [8];
  logic        m_fz, m_fs;

  always #5 clk = ~clk;

  alu_ctrl #(.WIDTH(16), .NREGS(8), .RAW(3)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_rd(cmd_rd),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm),
    .cmd_cond(cmd_cond), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_z(rsp_z), .rsp_sign(rsp_sign), .rsp_err(rsp_err), .rsp_skip(rsp_skip),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl), .alu_y(alu_y), .alu_z(alu_z),
    .alu_sign(alu_sign), .flag_z(flag_z), .flag_s(flag_s)
  );

  // Behavioural stand-in for the 16-bit ALU
  function automatic logic [15:0] alu_f(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
    case (c)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a + b;
      4'd3: return a ^ b;
      4'd4: return a - b;
      4'd5: return ~(a | b);
      4'd6: return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      4'd7: return a << b[3:0];
      4'd8: return a >> b[3:0];
      default: return 16'd0;
    endcase
  endfunction

  assign alu_y    = alu_f(alu_ctl, alu_a, alu_b);
  assign alu_z    = (alu_y == 16'd0);
  assign alu_sign = alu_y[15];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 16'd0;
    m_fz = 1'b0;
    m_fs = 1'b0;
  endtask

  function automatic logic cond_true(input logic [1:0] cond);
`ifdef ALU_CTRL_COND_EN
    return (cond == 2'd0) || (cond == 2'd1 && m_fz) || (cond == 2'd2 && !m_fz) || (cond == 2'd3 && m_fs);
`else
    return 1'b1;
`endif
  endfunction

  task automatic drive_cmd(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                           input logic [2:0] rs2, input logic ui, input logic [15:0] imm, input logic [1:0] cond);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    cmd_use_imm = ui; cmd_imm = imm; cmd_cond = cond;
  endtask

  // One complete command: accept, EXEC checks, response checks, optional backpressure
  task automatic run_cmd(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic ui, input logic [15:0] imm,
                         input logic [1:0] cond, input int hold);
    logic [15:0] a, b, y;
    logic        legal, load, ill, ok, ez, es;
    int          n;
    a     = m_rf[rs1];
    b     = ui ? imm : m_rf[rs2];
    legal = (op <= 4'd8);
    load  = (op == 4'd15);
    ill   = !legal && !load;
    ok    = cond_true(cond);
    y     = load ? imm : (legal ? alu_f(op, a, b) : 16'd0);
    ez    = ill ? 1'b0 : (y == 16'd0);
    es    = ill ? 1'b0 : y[15];
    drive_cmd(op, rd, rs1, rs2, ui, imm, cond);
    rsp_ready = (hold == 0);
    n = 0;
    while (!cmd_ready && n < 10) begin @(posedge clk); #1; n++; end
    chk("cmd_ready_before_accept", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_imm   = 16'($urandom);
    cmd_rd    = 3'($urandom);
    chk("exec_alu_a", alu_a, a);
    chk("exec_alu_b", alu_b, b);
    chk("exec_alu_ctl", alu_ctl, legal ? op : 4'd0);
    chk("exec_cmd_ready", cmd_ready, 0);
    chk("exec_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    chk("rsp_valid_latency", rsp_valid, 1);
    chk("rsp_data", rsp_data, y);
    if (!ill) begin
      chk("rsp_z", rsp_z, ez);
      chk("rsp_sign", rsp_sign, es);
    end
    chk("rsp_err", rsp_err, ill);
    chk("rsp_skip", rsp_skip, !ok);
    if (!ill && ok) begin
      m_rf[rd] = y;
      m_fz = (y == 16'd0);
      m_fs = y[15];
    end
    chk("flag_z", flag_z, m_fz);
    chk("flag_s", flag_s, m_fs);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_data", rsp_data, y);
      chk("hold_rsp_err", rsp_err, ill);
      chk("hold_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("post_hs_rsp_valid", rsp_valid, 0);
    chk("post_hs_cmd_ready", cmd_ready, 1);
    chk("post_hs_rsp_err", rsp_err, 0);
    chk("post_hs_rsp_skip", rsp_skip, 0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_use_imm = 1'b0; cmd_imm = '0; cmd_cond = '0;
    model_reset();
    #12;
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_alu_ctl", alu_ctl, 0);
    chk("reset_flag_z", flag_z, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run_cmd(4'd15, 3'd1, 3'd0, 3'd0, 1'b0, 16'd25, 2'd0, 0);
    run_cmd(4'd15, 3'd2, 3'd0, 3'd0, 1'b0, 16'h0000, 2'd0, 0);
    run_cmd(4'd15, 3'd3, 3'd0, 3'd0, 1'b0, 16'hFFF6, 2'd0, 0);
    run_cmd(4'd15, 3'd2, 3'd0, 3'd0, 1'b0, 16'd25, 2'd0, 0);
    for (int op = 0; op <= 8; op++) begin
      run_cmd(4'(op), 3'd4, 3'd1, 3'd2, 1'b0, 16'hDEAD, 2'd0, 0);
      run_cmd(4'd2, 3'd6, 3'd4, 3'd0, 1'b0, 16'd0, 2'd0, 0);
    end
    run_cmd(4'd12, 3'd1, 3'd3, 3'd2, 1'b1, 16'h7777, 2'd0, 0);
    run_cmd(4'd4, 3'd4, 3'd4, 3'd4, 1'b0, 16'd0, 2'd0, 0);
    run_cmd(4'd2, 3'd5, 3'd1, 3'd3, 1'b0, 16'd0, 2'd0, 5);
    run_cmd(4'd15, 3'd7, 3'd0, 3'd0, 1'b0, 16'h8001, 2'd1, 0);

    // Reset while LOAD r5=0x1234 is in EXEC
    drive_cmd(4'd15, 3'd5, 3'd0, 3'd0, 1'b0, 16'h1234, 2'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst = 1'b1; #1;
    chk("rst_exec_rsp_valid", rsp_valid, 0);
    chk("rst_exec_cmd_ready", cmd_ready, 1);
    model_reset();
    @(negedge clk); rst = 1'b0;
    run_cmd(4'd1, 3'd6, 3'd5, 3'd1, 1'b0, 16'd0, 2'd0, 0);

    // Reset while a response is pending
    drive_cmd(4'd15, 3'd2, 3'd0, 3'd0, 1'b0, 16'h00F0, 2'd0);
    rsp_ready = 1'b0;
    @(posedge clk); #1; cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_rsp_valid", rsp_valid, 1);
    rst = 1'b1; #1;
    chk("rst_resp_rsp_valid", rsp_valid, 0);
    chk("rst_resp_flag_z", flag_z, 0);
    model_reset();
    @(negedge clk); rst = 1'b0;
    run_cmd(4'd15, 3'd3, 3'd0, 3'd0, 1'b0, 16'd9, 2'd1, 0);

    for (int k = 0; k < 200; k++) begin
      logic [3:0] rop;
      rop = 4'($urandom_range(0, 15));
      run_cmd(rop, 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
              ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom), 2'($urandom), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_ctrl.md
Name: alu_ctrl

Overview:
- Command-driven sequencer that sits on the driving side of the existing 16-bit ALU (operands a/b, 4-bit ctl, result y, zero z, sign).
- Accepts one operation at a time over a valid/ready command interface.
- Reads operands from an internal register file, drives the ALU, captures y/z/sign, writes back, and returns the result over a valid/ready response interface.
- Replaces hand-sequenced stimulus as the ALU's operational front end.

Parameters:
WIDTH, 16, datapath width (matches ALU)
NREGS, 8, register file depth
RAW, 3, register index width (log2 NREGS)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  4  0..8 = ALU ctl code; 9..14 = illegal; 15 = LOAD immediate
cmd_rd  in  RAW  destination register
cmd_rs1  in  RAW  source for alu_a
cmd_rs2  in  RAW  source for alu_b
cmd_use_imm  in  1  1: alu_b = cmd_imm instead of rf[rs2]
cmd_imm  in  WIDTH  immediate
cmd_cond  in  2  condition code (see Optional Feature)
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when valid&ready
rsp_data  out  WIDTH  result written (or would-be result)
rsp_z  out  1  zero flag of this op
rsp_sign  out  1  sign flag of this op
rsp_err  out  1  illegal op
rsp_skip  out  1  op squashed by condition
alu_a  out  WIDTH  to ALU a
alu_b  out  WIDTH  to ALU b
alu_ctl  out  4  to ALU ctl
alu_y  in  WIDTH  from ALU y
alu_z  in  1  from ALU z
alu_sign  in  1  from ALU sign
flag_z  out  1  architectural zero flag
flag_s  out  1  architectural sign flag

Behaviour:
- Reset (async, immediate):
  - State IDLE; cmd_ready=1.
  - rsp_* = 0; alu_a/alu_b/alu_ctl = 0; flag_z = flag_s = 0.
  - All NREGS registers cleared to 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready=1.
  - On accept edge E0: latch op/rd/cond.
  - Load alu_a=rf[rs1], alu_b = use_imm ? imm : rf[rs2], alu_ctl = op (op forced to 0 for op>=9).
  - Go to EXEC.
- EXEC (one cycle, cmd_ready=0):
  - At E1, sample alu_y/alu_z/alu_sign.
  - Legal ALU op: rf[rd]<=alu_y; flag_z<=alu_z; flag_s<=alu_sign; rsp_data/z/sign<=same.
  - LOAD (15): rf[rd]<=imm; rsp_data=imm; rsp_z=(imm==0); rsp_sign=imm[WIDTH-1]; flags updated identically.
  - Illegal (9..14): no writeback, flags unchanged, rsp_err=1, rsp_data=0.
  - Set rsp_valid=1 and go to RESP.
- RESP:
  - Hold all rsp_* stable until rsp_ready.
  - On the handshake edge, rsp_valid=0, clear rsp_err/rsp_skip, go to IDLE.
  - rsp_ready may be high before rsp_valid. Minimum issue interval is 3 cycles.
- Latency: rsp_valid rises exactly 2 edges after command accept.
- Register file:
  - Read combinationally at accept.
  - Writeback at E1 precedes any later accept, so no forwarding is needed.
  - rd==rs1/rs2 is legal: reads the old value, writes the new one.
- cmd_valid during EXEC/RESP is ignored; the command must be held by the sender.
- Reset in EXEC or RESP:
  - Operation is abandoned, with no writeback if not yet at E1.
  - rsp_valid drops immediately; the block returns to IDLE.
- alu_a/alu_b/alu_ctl hold their last values outside EXEC.

Optional Feature:
- Macro: ALU_CTRL_COND_EN.
- Defined: cmd_cond selects 0=always, 1=if flag_z, 2=if !flag_z, 3=if flag_s, evaluated on architectural flags at E0.
  - False condition: no writeback, flags unchanged.
  - Response still issued at E1 with rsp_skip=1; rsp_data/z/sign carry the would-be result.
  - Illegal op with false condition reports rsp_err=1, rsp_skip=1.
- Undefined: cmd_cond ignored; rsp_skip tied 0; all ops execute.

Test Plan:
- Reset, then LOAD r1=25 (op15, imm 25) -> rsp_valid 2 cycles after accept; rsp_data=25, rsp_z=0, rsp_sign=0, flag_z=0.
- LOAD r2=0x0000, then LOAD r3=0xFFF6 (-10) -> rsp_z=1 then rsp_sign=1; flag_s=1, flag_z=0 after second.
- With real alu instantiated: r1=r2=25, ops 0..8 rd=r4 -> alu_a=alu_b=25, alu_ctl=op during EXEC; rsp_data/z/sign equal alu y/z/sign; a subsequent op reading r4 sees that value.
- op=12 -> rsp_err=1, rsp_data=0, rf and flags unchanged; next legal op accepted normally.
- rsp_ready held low 5 cycles -> rsp_* stable, cmd_ready=0 throughout; accept resumes the cycle after the handshake.
- Assert rst during EXEC of "LOAD r5=0x1234" -> rsp_valid=0 immediately, r5=0 after release, cmd_ready=1. With ALU_CTRL_COND_EN, cond=1 with flag_z=0 -> rsp_skip=1, rd unchanged.
